// File: rtl/sparse_chunk_writer.sv
// sparse_chunk_writer: builds sparsemap + compacted nonzero bytes into a double-buffered chunk store.
// Optional macro CHUNK_PADDING_EN: variable chunk length from chunk_len_i with last-beat lane masking.
`default_nettype none

module sparse_chunk_writer #(
  parameter int BUS_SIZE       = 8,
  parameter int MEM_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = MEM_SIZE / BUS_SIZE,
  localparam int LEN_W         = $clog2(MEM_SIZE) + 1,
  localparam int CNT_W         = $clog2(WR_DAT_CYC_NUM)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  input  logic                  dense_valid_i,
  output logic                  dense_ready_o,
  input  logic [LEN_W-1:0]      chunk_len_i,
  input  logic                  buf_release_i,
  input  logic                  buf_release_sel_i,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic                  wr_sel_o,
  output logic                  wr_last_o,
  output logic [1:0]            buf_full_o
);

  localparam int IDX_W = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
  localparam logic [0:0] S_FILL  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  logic [0:0]            state, state_n;
  logic [CNT_W-1:0]      cnt_r, cnt_n;
  logic                  sel_r, sel_n;
  logic [1:0]            full_r, full_n, set_mask, clr_mask;
  logic                  accept, last_beat;
  logic [BUS_SIZE-1:0]   lane_en, nz;
  logic [7:0]            comp [BUS_SIZE];
  logic [BUS_SIZE*8-1:0] comp_flat;
  logic [IDX_W-1:0]      pos;

  assign accept = dense_valid_i && dense_ready_o;

`ifdef CHUNK_PADDING_EN
  logic [LEN_W-1:0] len_r, len_cur, len_eff, beats, rem;

  // The first beat of a chunk uses the live length; later beats use the sampled copy.
  always_comb begin
    len_cur = (cnt_r == '0) ? chunk_len_i : len_r;
    len_eff = (len_cur == '0 || len_cur > LEN_W'(MEM_SIZE)) ? LEN_W'(MEM_SIZE) : len_cur;
    beats   = (len_eff + LEN_W'(BUS_SIZE - 1)) / LEN_W'(BUS_SIZE);
    if (beats > LEN_W'(WR_DAT_CYC_NUM))
      beats = LEN_W'(WR_DAT_CYC_NUM);
    rem       = len_eff % LEN_W'(BUS_SIZE);
    last_beat = (LEN_W'(cnt_r) == beats - LEN_W'(1));
    for (int i = 0; i < BUS_SIZE; i++)
      lane_en[i] = !(last_beat && (rem != '0) && (LEN_W'(i) >= rem));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      len_r <= '0;
    else if (accept && cnt_r == '0)
      len_r <= chunk_len_i;
  end
`else
  logic unused_len;
  assign unused_len = ^chunk_len_i;
  assign last_beat  = (cnt_r == CNT_W'(WR_DAT_CYC_NUM - 1));
  assign lane_en    = '1;
`endif

  always_comb begin
    for (int i = 0; i < BUS_SIZE; i++)
      nz[i] = lane_en[i] && (dense_data_i[i*8 +: 8] != 8'h00);
  end

  // Each nonzero byte lands in the lane equal to the number of nonzero lanes below it.
  always_comb begin
    pos = '0;
    for (int i = 0; i < BUS_SIZE; i++)
      comp[i] = 8'h00;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (nz[i]) begin
        comp[pos] = dense_data_i[i*8 +: 8];
        pos       = pos + IDX_W'(1);
      end
    end
  end

  for (genvar g = 0; g < BUS_SIZE; g++) begin : g_flat
    assign comp_flat[g*8 +: 8] = comp[g];
  end

  always_comb begin
    set_mask = (accept && last_beat) ? (2'b01 << sel_r) : 2'b00;
    clr_mask = buf_release_i ? (2'b01 << buf_release_sel_i) : 2'b00;
    full_n   = (full_r & ~clr_mask) | set_mask;
    sel_n    = sel_r ^ (accept && last_beat);
    cnt_n    = cnt_r;
    if (accept)
      cnt_n = last_beat ? '0 : cnt_r + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      state <= S_STALL;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = full_n[sel_n] ? S_STALL : S_FILL;
  end

  always_comb begin
    dense_ready_o = (state == S_FILL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r             <= '0;
      sel_r             <= 1'b0;
      full_r            <= 2'b00;
      wr_valid_o        <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      wr_last_o         <= 1'b0;
    end else begin
      cnt_r             <= cnt_n;
      sel_r             <= sel_n;
      full_r            <= full_n;
      wr_valid_o        <= accept;
      wr_sparsemap_o    <= accept ? nz : '0;
      wr_nonzero_data_o <= accept ? comp_flat : '0;
      wr_count_o        <= accept ? cnt_r : '0;
      wr_sel_o          <= accept && sel_r;
      wr_last_o         <= accept && last_beat;
    end
  end

  assign buf_full_o = full_r;

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_writer.sv
// Scoreboard bench for sparse_chunk_writer: reference model predicts each write beat, a monitor checks them.
`default_nettype none

module tb_sparse_chunk_writer;
  localparam int BUS   = 8;
  localparam int MEM   = 32;
  localparam int WR    = MEM / BUS;
  localparam int LEN_W = $clog2(MEM) + 1;
  localparam int CNT_W = $clog2(WR);

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic [BUS*8-1:0]   dense_data_i = '0;
  logic               dense_valid_i = 1'b0;
  logic               dense_ready_o;
  logic [LEN_W-1:0]   chunk_len_i = '0;
  logic               buf_release_i = 1'b0;
  logic               buf_release_sel_i = 1'b0;
  logic [BUS-1:0]     wr_sparsemap_o;
  logic [BUS*8-1:0]   wr_nonzero_data_o;
  logic               wr_valid_o;
  logic [CNT_W-1:0]   wr_count_o;
  logic               wr_sel_o;
  logic               wr_last_o;
  logic [1:0]         buf_full_o;

  sparse_chunk_writer #(.BUS_SIZE(BUS), .MEM_SIZE(MEM), .WR_DAT_CYC_NUM(WR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dense_data_i(dense_data_i), .dense_valid_i(dense_valid_i), .dense_ready_o(dense_ready_o),
    .chunk_len_i(chunk_len_i), .buf_release_i(buf_release_i), .buf_release_sel_i(buf_release_sel_i),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o), .wr_valid_o(wr_valid_o),
    .wr_count_o(wr_count_o), .wr_sel_o(wr_sel_o), .wr_last_o(wr_last_o), .buf_full_o(buf_full_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BUS-1:0]   smap;
    logic [BUS*8-1:0] data;
    logic [CNT_W-1:0] cnt;
    logic             sel;
    logic             last;
    int               stamp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model state: what the design should hold after the most recent edge.
  bit [1:0] mfull = 2'b00;
  bit       msel = 1'b0;
  int       mcnt = 0;
  int       mlen = 0;
  bit       mready = 1'b0;
  bit       in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input logic [BUS*8-1:0] d, input int len,
                      input bit rel, input bit rsel, input bit rst_n);
    int beats, nvalid, eff;
    bit last;
    logic [7:0] nzq[$];
    exp_t e;
    @(negedge clk);
    chk("dense_ready", 64'(dense_ready_o), 64'(mready));
    chk("buf_full", 64'(buf_full_o), 64'(mfull));
    if (in_reset) begin
      chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
      chk("rst_wr_sparsemap", 64'(wr_sparsemap_o), 64'd0);
      chk("rst_wr_data", 64'(wr_nonzero_data_o), 64'd0);
      chk("rst_wr_misc", 64'({wr_count_o, wr_sel_o, wr_last_o}), 64'd0);
    end
    rst_i             = rst_n;
    dense_valid_i     = v;
    dense_data_i      = d;
    chunk_len_i       = LEN_W'(len);
    buf_release_i     = rel;
    buf_release_sel_i = rsel;
    if (!rst_n) begin
      mfull = 2'b00; msel = 1'b0; mcnt = 0; mready = 1'b0; in_reset = 1'b1;
    end else begin
      in_reset = 1'b0;
      last = 1'b0;
      if (v && mready) begin
        if (mcnt == 0) mlen = len;
`ifdef CHUNK_PADDING_EN
        eff   = (mlen == 0 || mlen > MEM) ? MEM : mlen;
        beats = (eff + BUS - 1) / BUS;
        if (beats > WR) beats = WR;
        last   = (mcnt == beats - 1);
        nvalid = (last && (eff % BUS) != 0) ? eff % BUS : BUS;
`else
        eff    = MEM;
        beats  = WR;
        last   = (mcnt == beats - 1);
        nvalid = BUS;
`endif
        e.smap = '0;
        e.data = '0;
        for (int i = 0; i < nvalid; i++) begin
          if (d[i*8 +: 8] != 8'h00) begin
            e.smap[i] = 1'b1;
            nzq.push_back(d[i*8 +: 8]);
          end
        end
        for (int k = 0; k < nzq.size(); k++) e.data[k*8 +: 8] = nzq[k];
        e.cnt   = CNT_W'(mcnt);
        e.sel   = msel;
        e.last  = last;
        e.stamp = cyc + 1;
        q.push_back(e);
        mcnt = last ? 0 : mcnt + 1;
      end
      // Release is applied first so that a completion of the same buffer wins.
      if (rel) mfull[rsel] = 1'b0;
      if (last) begin
        mfull[msel] = 1'b1;
        msel = ~msel;
      end
      mready = !mfull[msel];
    end
  endtask

  function automatic logic [BUS*8-1:0] rand_beat();
    logic [BUS*8-1:0] d;
    for (int i = 0; i < BUS; i++)
      d[i*8 +: 8] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    return d;
  endfunction

  // Monitor: every write beat must match the oldest prediction, exactly one cycle after acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].stamp < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_beat: got no wr_valid_o expected beat of cycle %0d (now %0d)", q[0].stamp, cyc);
        void'(q.pop_front());
      end
      if (wr_valid_o === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got wr_valid_o=1 expected none (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("beat_latency", 64'(cyc), 64'(e.stamp));
          chk("wr_sparsemap", 64'(wr_sparsemap_o), 64'(e.smap));
          chk("wr_nonzero_data", 64'(wr_nonzero_data_o), 64'(e.data));
          chk("wr_count", 64'(wr_count_o), 64'(e.cnt));
          chk("wr_sel", 64'(wr_sel_o), 64'(e.sel));
          chk("wr_last", 64'(wr_last_o), 64'(e.last));
        end
      end
    end
  end

  initial begin
    logic [BUS*8-1:0] ff_beat;
    ff_beat = '1;
    repeat (2) @(posedge clk);
    step(0, '0, MEM, 0, 0, 0);
    step(0, '0, MEM, 0, 0, 1);
    // Compaction example, then fill both buffers without releasing.
    step(1, 64'h0009_0000_0700_0500, MEM, 0, 0, 1);
    for (int i = 0; i < 7; i++) step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    step(0, '0, MEM, 1, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    // Completion of buffer 0 with release of buffer 1 in the same cycle.
    for (int i = 0; i < 2; i++) step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 1, 1, 1);
    // Buffer 1 completes while buffer 0 is released.
    for (int i = 0; i < 3; i++) step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 1, 0, 1);
    // Buffer 0 completes while it is also being released: it must stay full.
    for (int i = 0; i < 3; i++) step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 1, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    // Free both, start a chunk, reset in the middle of it.
    step(0, '0, MEM, 1, 0, 1);
    step(0, '0, MEM, 1, 1, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 0);
    step(1, rand_beat(), MEM, 0, 0, 0);
    step(1, rand_beat(), MEM, 0, 0, 1);
    step(1, rand_beat(), MEM, 0, 0, 1);
`ifdef CHUNK_PADDING_EN
    step(0, '0, MEM, 1, 0, 1);
    step(0, '0, MEM, 1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, rand_beat(), MEM, 0, 0, 1);
    step(0, '0, MEM, 1, 0, 1);
    step(0, '0, MEM, 1, 1, 1);
    step(1, ff_beat, 10, 0, 0, 1);
    step(1, ff_beat, 10, 0, 0, 1);
`endif
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 3) != 0, rand_beat(), int'($urandom_range(0, 40)),
           $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 499) != 0);
    end
    for (int n = 0; n < 4; n++) step(0, '0, MEM, 0, 0, 1);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sparse_chunk_writer.md
# sparse_chunk_writer

- Producer side of the sparse data-chunk buffers.
- Accepts dense activation or filter bytes, `BUS_SIZE` lanes per beat, and builds each beat's sparsemap (one bit per nonzero byte).
- Compacts the nonzero bytes into the low lanes and issues the double-buffered write stream (`wr_sparsemap`, `wr_nonzero_data`, `wr_valid`, `wr_count`, `wr_sel`) that the chunk storage consumes.
- Tracks ownership of both chunk buffers and back-pressures the dense source until the reader releases a buffer.

## Interface
- `BUS_SIZE`, default 8: byte lanes per beat.
- `MEM_SIZE`, default 32: bytes per chunk buffer.
- `WR_DAT_CYC_NUM`, default `MEM_SIZE/BUS_SIZE` (4): maximum beats per chunk.
- `clk_i` input, 1: clock, rising edge.
- `rst_i` input, 1: synchronous, active-low reset.
- `dense_data_i` input, `BUS_SIZE`×8: dense bytes; lane 0 = lowest channel.
- `dense_valid_i` input, 1: beat offered.
- `dense_ready_o` output, 1: beat accepted when valid && ready.
- `chunk_len_i` input, `$clog2(MEM_SIZE)+1`: channels in the current chunk; sampled on the first beat of each chunk.
- `buf_release_i` input, 1: reader frees a buffer.
- `buf_release_sel_i` input, 1: index of the buffer being freed.
- `wr_sparsemap_o` output, `BUS_SIZE`: bit i = lane i nonzero.
- `wr_nonzero_data_o` output, `BUS_SIZE`×8: compacted nonzero bytes, ascending lane order from lane 0; unused lanes 0x00.
- `wr_valid_o` output, 1: write beat valid.
- `wr_count_o` output, `$clog2(WR_DAT_CYC_NUM)`: beat index within the chunk.
- `wr_sel_o` output, 1: target buffer.
- `wr_last_o` output, 1: final beat of the chunk.
- `buf_full_o` output, 2: per-buffer full flags.

## Operation
- Two states:
  - FILL: `dense_ready_o`=1.
  - STALL: `dense_ready_o`=0; entered whenever `buf_full[sel_r]`=1.
  - `dense_ready_o` = `!buf_full[sel_r]`, decoded from registers only; there is no combinational path from `dense_valid_i`.
- On each accepted beat:
  - Sparsemap bit i = (`dense_data_i[i]` != 0).
  - Compaction: the k-th set bit (counting from lane 0) places its byte in output lane k.
  - Outputs are registered with `wr_count_o` = `cnt_r` and `wr_sel_o` = `sel_r`.
- Beat counter `cnt_r`:
  - Increments on each accepted beat.
  - On the chunk's last beat: `cnt_r` returns to 0, `wr_last_o`=1, `buf_full[sel_r]` sets, `sel_r` toggles.
- Release: `buf_release_i` clears `buf_full[buf_release_sel_i]`. Releasing a buffer that is not full is ignored.
- Release and completion in the same cycle:
  - Different buffers: both take effect.
  - Same buffer: the set wins. A buffer cannot be freed in the cycle it fills.
- Both buffers full: STALL until a release. The accepted beat after release goes to `sel_r`.
- Reset (`rst_i`=0 at a clock edge), including mid-chunk:
  - `cnt_r`=0, `sel_r`=0, `buf_full`=00, any partial chunk discarded.
  - All outputs 0 except `dense_ready_o`=0 while in reset and 1 on the first cycle after reset.

## Timing
- Latency: accepted beat at edge N → `wr_*` outputs valid for exactly the cycle after edge N. `wr_valid_o` is a 1-cycle pulse per beat.
- No `wr_*` back-pressure: the storage accepts every `wr_valid_o` beat.
- `buf_full_o` updates at the edge following the final beat; `dense_ready_o` drops in that same cycle if the next buffer is full.
- Release takes effect at the next edge; `dense_ready_o` rises the cycle after `buf_release_i`.
- Sustained throughput: 1 beat/cycle while a buffer is free.

## Configuration
- `CHUNK_PADDING_EN` defined:
  - Chunk length = ceil(`chunk_len_i`/`BUS_SIZE`) beats, clamped to 1..`WR_DAT_CYC_NUM`; `chunk_len_i`=0 or >`MEM_SIZE` is treated as `MEM_SIZE`.
  - In the last beat, lanes at index ≥ (`chunk_len_i` mod `BUS_SIZE`), when that modulus is nonzero, are forced to sparsemap 0 / data excluded.
- `CHUNK_PADDING_EN` undefined: every chunk is exactly `WR_DAT_CYC_NUM` beats, `chunk_len_i` is ignored, and no lane masking is applied.

## Test plan
- Compaction: beat lanes0..7 = {00,05,00,07,00,00,09,00} → `wr_sparsemap_o`=0x4A, data lanes0..2 = {05,07,09}, lanes 3..7 = 00, `wr_count_o`=0, asserted 1 cycle after acceptance.
- Full chunk (macro off): 4 consecutive beats → `wr_count_o` 0,1,2,3, `wr_last_o` on beat 3, `buf_full_o`=01, `wr_sel_o` of the next chunk = 1.
- Back-pressure: 8 beats with no release → `buf_full_o`=11 and `dense_ready_o`=0. Release buffer 0 → ready rises the next cycle and the next beat carries `wr_sel_o`=0.
- Simultaneous release and completion: buffer 1 completes while `buf_release_sel_i`=0 → `buf_full_o`=10. Same-buffer case → the buffer stays full.
- `CHUNK_PADDING_EN`, `chunk_len_i`=10: 2 beats; beat 1 lanes 2..7 masked (all-FF input → sparsemap 0x03); `wr_last_o` on `wr_count_o`=1.
- Reset asserted after beat 2 of a chunk → all outputs 0. First post-reset beat has `wr_count_o`=0, `wr_sel_o`=0, and `buf_full_o`=00.
